inst_cache_responder: RTL
=========================

# inst_cache_responder

Responder side of the fetch port: accepts the instruction fetch stage's per-cycle read request (byte PC plus read enable) and returns the 32-bit instruction word. It is a direct-mapped instruction cache. Misses refill one full line from backing memory over a simple request/beat bus. While a miss is outstanding it raises a busy flag, and the hazard unit ORs that flag into the fetch stall.

## Interface
Parameters:
- LINES, 16, number of cache lines (power of two)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two)

Ports:
- CLK  in  1  system clock, rising edge
- EXT_RESET_N  in  1  asynchronous, active-low reset
- MEM_ADDR1  in  32  fetch byte address; bits [1:0] ignored
- MEM_READ1  in  1  fetch request, sampled every rising edge
- MEM_INV  in  1  invalidate all lines (fence.i), single-cycle pulse
- MEM_DOUT1  out  32  instruction word
- MEM_BUSY1  out  1  miss outstanding; fetch must stall
- REFILL_REQ  out  1  refill request to backing memory
- REFILL_ADDR  out  32  line-aligned base address of the refill
- REFILL_RVALID  in  1  one refill data beat this cycle
- REFILL_RDATA  in  32  refill beat data, word order ascending

## Operation
- Address split (defaults): word = addr[3:2], index = addr[7:4], tag = addr[31:8]. Widths are derived from the parameters.
- Request register:
  - Captures MEM_ADDR1 and sets req_valid when MEM_READ1=1 and MEM_BUSY1=0.
  - When MEM_READ1=0 and not busy, req_valid is cleared.
  - While busy, the request register is frozen and input changes are ignored.
- FSM states:
  - LOOKUP:
    - req_valid and hit: MEM_DOUT1 = stored word, MEM_BUSY1=0, and the output hold register is loaded.
    - req_valid and miss: MEM_BUSY1=1 (combinational), next state REFILL.
    - req_valid=0: MEM_DOUT1 = held last word, MEM_BUSY1=0.
  - REFILL:
    - REFILL_REQ=1, REFILL_ADDR = {tag, index, zeros}.
    - Each REFILL_RVALID beat writes the next word; a beat counter runs 0..WORDS_PER_LINE-1.
    - After the last beat: write the tag, set valid, drop REFILL_REQ, and go to LOOKUP. The lookup then hits.
    - MEM_BUSY1=1 throughout REFILL. MEM_DOUT1 = 0x00000013 (NOP).
- Invalidate:
  - MEM_INV clears all valid bits at the next edge.
  - If MEM_INV arrives during REFILL, the refill still completes but its line is not marked valid, so the following LOOKUP misses and refills again.
  - If MEM_INV coincides with a hit in LOOKUP, the hit is still delivered this cycle.
- The refill bus needs no backpressure. Backing memory must not issue more than WORDS_PER_LINE beats per request. Beats arriving while REFILL_REQ=0 are ignored.

## Timing
- Hit latency: 1 cycle. A request sampled at edge N gives data valid after edge N (during cycle N+1), matching a synchronous BRAM port.
- Miss penalty: 1 lookup cycle + WORDS_PER_LINE beats + 1 lookup cycle. With a zero-wait backing memory this is 6 cycles at the defaults.
- REFILL_REQ asserts on the edge after the miss is detected. It deasserts on the edge that accepts the last beat.
- Reset (asynchronous assert, synchronous release behaviour):
  - Outputs: MEM_DOUT1=0x00000013, MEM_BUSY1=0, REFILL_REQ=0, REFILL_ADDR=0.
  - Internal: all valid bits 0, req_valid=0, FSM=LOOKUP, beat counter 0.
- Reset mid-refill aborts immediately: REFILL_REQ drops asynchronously and the partial line stays invalid.
- Back-to-back hits to different lines sustain one word per cycle.
- Stalled fetch (MEM_READ1=0): MEM_DOUT1 is stable at the last delivered word.

## Structure
- Package inst_cache_pkg holds:
  - state enum (LOOKUP, REFILL)
  - NOP constant 32'h00000013
  - helper localparams for index/word/tag widths from LINES and WORDS_PER_LINE
- One sub-module, icache_line_store:
  - tag and valid arrays plus data array
  - asynchronous read by index/word
  - synchronous word write
  - tag/valid write
  - global valid clear
- The top level contains the request register, FSM, beat counter, output hold register and hit compare.

## Test plan
- Cold miss: reset, fetch 0x00000000 → BUSY=1 and REFILL_REQ with REFILL_ADDR=0x0. Feed beats 0x11,0x22,0x33,0x44 → BUSY drops and DOUT1=0x11.
- Sequential hits: after the cold miss, fetch 0x4, 0x8, 0xC on consecutive cycles → DOUT1=0x22, 0x33, 0x44 on consecutive cycles with no BUSY.
- Conflict miss: fetch 0x100 (same index 0, tag 1) → refill at 0x100. A subsequent fetch of 0x0 misses again.
- Stall hold: hit delivering 0x33, then MEM_READ1=0 for 3 cycles with MEM_ADDR1 changing → DOUT1 stays 0x33 and BUSY=0.
- Invalidate during refill: MEM_INV pulse at beat 2 → refill finishes, the lookup misses, and a second REFILL_REQ is issued to the same address.
- Reset mid-refill: assert EXT_RESET_N low after beat 1 → REFILL_REQ=0 and DOUT1=0x13 immediately. Fetching the same address afterwards misses.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared types, constants and width helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

    typedef enum logic [0:0] {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DEF_LINES          = 16;
    localparam int unsigned DEF_WORDS_PER_LINE = 4;

    function automatic int unsigned index_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned word_w(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Everything above the line offset and index is tag.
    function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words_per_line);
        return ADDR_W - 2 - index_w(lines) - word_w(words_per_line);
    endfunction

endpackage

// File: rtl/inst_cache_responder_if.sv
// Fetch port plus refill bus of the instruction cache, bundled for the responder and its driver.
interface inst_cache_responder_if;

    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic        MEM_INV;
    logic [31:0] MEM_DOUT1;
    logic        MEM_BUSY1;
    logic        REFILL_REQ;
    logic [31:0] REFILL_ADDR;
    logic        REFILL_RVALID;
    logic [31:0] REFILL_RDATA;

    // Fetch stage and backing memory side.
    modport master (
        output MEM_ADDR1, MEM_READ1, MEM_INV, REFILL_RVALID, REFILL_RDATA,
        input  MEM_DOUT1, MEM_BUSY1, REFILL_REQ, REFILL_ADDR
    );

    // Cache side.
    modport slave (
        input  MEM_ADDR1, MEM_READ1, MEM_INV, REFILL_RVALID, REFILL_RDATA,
        output MEM_DOUT1, MEM_BUSY1, REFILL_REQ, REFILL_ADDR
    );

endinterface

// File: rtl/icache_line_store.sv
// Tag/valid/data storage of the instruction cache: async read, sync word and tag writes.
module icache_line_store
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [index_w(LINES)-1:0]                index,
    input  logic [word_w(WORDS_PER_LINE)-1:0]        rd_word,
    output logic [31:0]                              rd_data,
    output logic [tag_w(LINES, WORDS_PER_LINE)-1:0]  rd_tag,
    output logic                                     rd_valid,
    input  logic                                     word_we,
    input  logic [word_w(WORDS_PER_LINE)-1:0]        wr_word,
    input  logic [31:0]                              wr_data,
    input  logic                                     tag_we,
    input  logic [tag_w(LINES, WORDS_PER_LINE)-1:0]  wr_tag,
    input  logic                                     wr_valid,
    input  logic                                     clear_all
);

    localparam int unsigned TAG_W = tag_w(LINES, WORDS_PER_LINE);

    logic [31:0]      data_q [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    assign rd_data  = data_q[{index, rd_word}];
    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];

    // Data and tag arrays carry no reset; only the valid bits define cache contents.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[{index, wr_word}] <= wr_data;
        end
        if (tag_we) begin
            tag_q[index] <= wr_tag;
        end
    end

    // A global clear outranks a simultaneous line fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[index] <= wr_valid;
        end
    end

endmodule

// File: rtl/inst_cache_responder.sv
// Direct-mapped instruction cache answering the fetch port; misses refill a full line over a beat bus.
module inst_cache_responder
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input logic                   CLK,
    input logic                   EXT_RESET_N,
    inst_cache_responder_if.slave bus
);

    localparam int unsigned INDEX_W  = index_w(LINES);
    localparam int unsigned WORD_W   = word_w(WORDS_PER_LINE);
    localparam int unsigned TAG_W    = tag_w(LINES, WORDS_PER_LINE);
    localparam int unsigned OFFSET_W = WORD_W + 2;

    state_e             state, state_d;
    logic               req_valid;
    logic [31:2]        req_addr;
    logic [WORD_W-1:0]  beat_cnt, beat_d;
    logic               refill_req, refill_req_d;
    logic [31:0]        refill_addr, refill_addr_d;
    logic               inv_pending, inv_pending_d;
    logic [31:0]        hold, hold_d;

    logic               busy_c;
    logic [31:0]        dout_c;
    logic               word_we_c;
    logic               tag_we_c;
    logic               wr_valid_c;
    logic               hit_c;

    logic [INDEX_W-1:0] req_index;
    logic [WORD_W-1:0]  req_word;
    logic [TAG_W-1:0]   req_tag;
    logic [31:0]        rd_data;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;

    // Byte-offset bits of the fetch address are deliberately dropped.
    logic unused_byte_offset;
    assign unused_byte_offset = ^bus.MEM_ADDR1[1:0];

    assign req_word  = req_addr[OFFSET_W-1:2];
    assign req_index = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign req_tag   = req_addr[31:OFFSET_W+INDEX_W];
    assign hit_c     = rd_valid && (rd_tag == req_tag);

    icache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk       (CLK),
        .rst_n     (EXT_RESET_N),
        .index     (req_index),
        .rd_word   (req_word),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .word_we   (word_we_c),
        .wr_word   (beat_cnt),
        .wr_data   (bus.REFILL_RDATA),
        .tag_we    (tag_we_c),
        .wr_tag    (req_tag),
        .wr_valid  (wr_valid_c),
        .clear_all (bus.MEM_INV)
    );

    // Request register: frozen while a miss is outstanding.
    always_ff @(posedge CLK or negedge EXT_RESET_N) begin
        if (!EXT_RESET_N) begin
            req_valid <= 1'b0;
            req_addr  <= '0;
        end else if (!busy_c) begin
            req_valid <= bus.MEM_READ1;
            if (bus.MEM_READ1) begin
                req_addr <= bus.MEM_ADDR1[31:2];
            end
        end
    end

    always_ff @(posedge CLK or negedge EXT_RESET_N) begin
        if (!EXT_RESET_N) begin
            state       <= LOOKUP;
            beat_cnt    <= '0;
            refill_req  <= 1'b0;
            refill_addr <= '0;
            inv_pending <= 1'b0;
            hold        <= NOP;
        end else begin
            state       <= state_d;
            beat_cnt    <= beat_d;
            refill_req  <= refill_req_d;
            refill_addr <= refill_addr_d;
            inv_pending <= inv_pending_d;
            hold        <= hold_d;
        end
    end

    always_comb begin
        state_d       = state;
        beat_d        = beat_cnt;
        refill_req_d  = refill_req;
        refill_addr_d = refill_addr;
        inv_pending_d = inv_pending;
        hold_d        = hold;
        busy_c        = 1'b0;
        dout_c        = hold;
        word_we_c     = 1'b0;
        tag_we_c      = 1'b0;
        wr_valid_c    = 1'b0;

        case (state)
            LOOKUP: begin
                if (req_valid) begin
                    if (hit_c) begin
                        dout_c = rd_data;
                        hold_d = rd_data;
                    end else begin
                        busy_c        = 1'b1;
                        state_d       = REFILL;
                        refill_req_d  = 1'b1;
                        refill_addr_d = {req_addr[31:OFFSET_W], OFFSET_W'(0)};
                        beat_d        = '0;
                        inv_pending_d = 1'b0;
                    end
                end
            end
            REFILL: begin
                busy_c        = 1'b1;
                dout_c        = NOP;
                inv_pending_d = inv_pending || bus.MEM_INV;
                if (refill_req && bus.REFILL_RVALID) begin
                    word_we_c = 1'b1;
                    beat_d    = beat_cnt + WORD_W'(1);
                    // Last beat: commit the tag; an invalidate seen during the fill leaves the line invalid.
                    if (beat_cnt == WORD_W'(WORDS_PER_LINE - 1)) begin
                        tag_we_c     = 1'b1;
                        wr_valid_c   = !(inv_pending || bus.MEM_INV);
                        state_d      = LOOKUP;
                        refill_req_d = 1'b0;
                        beat_d       = '0;
                    end
                end
            end
            default: begin
                state_d = LOOKUP;
            end
        endcase
    end

    assign bus.MEM_DOUT1   = dout_c;
    assign bus.MEM_BUSY1   = busy_c;
    assign bus.REFILL_REQ  = refill_req;
    assign bus.REFILL_ADDR = refill_addr;

endmodule
